// File: rtl/instr_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_if
// Bundles the fetch unit's PC, program-load and control-stage signals.
//   run                      : level, fetching proceeds while high
//   count1/count2            : PC low/high halves forming the fetch address
//   pc_enable/jmp/jmploc     : PC advance pulse, jump flag and jump target
//   prog_we/prog_addr/prog_data : program memory write port
//   ir/opcode/operand        : instruction register and its two halves
//   instr_valid/instr_ack    : valid/ack handshake to the control stage
//   halted                   : high while fetching is halted
// Modport master is the fetch unit, slave is its environment.
// ---------------------------------------------------------------------------
interface instr_fetch_unit_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic                  run;
  logic [ADDR_W/2-1:0]   count1;
  logic [ADDR_W/2-1:0]   count2;
  logic                  pc_enable;
  logic                  jmp;
  logic [ADDR_W-1:0]     jmploc;
  logic                  prog_we;
  logic [ADDR_W-1:0]     prog_addr;
  logic [DATA_W-1:0]     prog_data;
  logic [DATA_W-1:0]     ir;
  logic [DATA_W/2-1:0]   opcode;
  logic [DATA_W/2-1:0]   operand;
  logic                  instr_valid;
  logic                  instr_ack;
  logic                  halted;

  modport master (
    input  run, count1, count2, prog_we, prog_addr, prog_data, instr_ack,
    output pc_enable, jmp, jmploc, ir, opcode, operand, instr_valid, halted
  );

  modport slave (
    output run, count1, count2, prog_we, prog_addr, prog_data, instr_ack,
    input  pc_enable, jmp, jmploc, ir, opcode, operand, instr_valid, halted
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Fetch/decode stage behind the program counter. Reads a 2**ADDR_W x DATA_W
// program memory at {count2,count1}, latches the word into ir, offers it to
// the control stage with instr_valid/instr_ack, then pulses pc_enable once
// (with jmp/jmploc for a jump opcode) so the PC advances exactly once per
// completed instruction. A halt opcode parks the unit in HALT until run drops.
// Ports:
//   clk   : system clock
//   rst   : synchronous reset, active high
//   bus   : instr_fetch_unit_if.master (PC, program-load, handshake signals)
//   step  : single-step request, present only with STEP_MODE_EN
// Optional feature macro: STEP_MODE_EN -- leaving IDLE needs run=1 and a
// rising edge on step; every instruction returns to IDLE afterwards.
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int          DATA_W     = 8,
  parameter int          ADDR_W     = 4,
  parameter int          SETTLE_CYC = 1,
  parameter logic [3:0]  OPC_JMP    = 4'h8,
  parameter logic [3:0]  OPC_HLT    = 4'hF
) (
  input logic               clk,
  input logic               rst,
  instr_fetch_unit_if.master bus
`ifdef STEP_MODE_EN
  ,
  input logic               step
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXEC    = 3'd3,
    ADVANCE = 3'd4,
    SETTLE  = 3'd5,
    HALT    = 3'd6
  } state_t;

  localparam logic [2:0] SETTLE_LAST = 3'(SETTLE_CYC - 1);

  state_t                state_r;
  logic [DATA_W-1:0]     mem_r [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0]     ir_r;
  logic                  pc_enable_r;
  logic                  jmp_r;
  logic [ADDR_W-1:0]     jmploc_r;
  logic                  instr_valid_r;
  logic                  halted_r;
  logic [2:0]            settle_cnt_r;

  logic [ADDR_W-1:0]     addr_s;
  logic [DATA_W/2-1:0]   op_s;
  logic [DATA_W/2-1:0]   operand_s;
  logic                  prog_ok_s;
  logic                  start_s;
  logic                  resume_s;

  assign addr_s    = {bus.count2, bus.count1};
  assign op_s      = ir_r[DATA_W-1:DATA_W/2];
  assign operand_s = ir_r[DATA_W/2-1:0];
  // Loads are only safe while nothing is being fetched; reset blocks them too.
  assign prog_ok_s = bus.prog_we && !rst && ((state_r == IDLE) || (state_r == HALT));

`ifdef STEP_MODE_EN
  logic step_r;
  logic step_prev_r;

  // Register step and keep its previous value for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_r      <= 1'b0;
      step_prev_r <= 1'b0;
    end else begin
      step_r      <= step;
      step_prev_r <= step_r;
    end
  end

  assign start_s  = bus.run && step_r && !step_prev_r;
  assign resume_s = 1'b0;  // one instruction per step edge
`else
  assign start_s  = bus.run;
  assign resume_s = bus.run;
`endif

  // Program memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (prog_ok_s) begin
      mem_r[bus.prog_addr] <= bus.prog_data;
    end
  end

  // Fetch/decode/handshake FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      ir_r          <= {DATA_W{1'b0}};
      pc_enable_r   <= 1'b0;
      jmp_r         <= 1'b0;
      jmploc_r      <= {ADDR_W{1'b0}};
      instr_valid_r <= 1'b0;
      halted_r      <= 1'b0;
      settle_cnt_r  <= 3'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_s && !bus.prog_we) state_r <= FETCH;
          else                         state_r <= IDLE;
        end
        FETCH: begin
          ir_r    <= mem_r[addr_s];
          state_r <= DECODE;
        end
        DECODE: begin
          if (op_s == OPC_HLT) begin
            halted_r <= 1'b1;
            state_r  <= HALT;
          end else begin
            instr_valid_r <= 1'b1;
            state_r       <= EXEC;
          end
        end
        EXEC: begin
          // pc_enable is raised on the ack edge so it is high during ADVANCE.
          if (bus.instr_ack) begin
            instr_valid_r <= 1'b0;
            pc_enable_r   <= 1'b1;
            if (op_s == OPC_JMP) begin
              jmp_r    <= 1'b1;
              jmploc_r <= operand_s;
            end else begin
              jmp_r    <= 1'b0;
            end
            state_r <= ADVANCE;
          end else begin
            state_r <= EXEC;
          end
        end
        ADVANCE: begin
          pc_enable_r  <= 1'b0;
          jmp_r        <= 1'b0;
          settle_cnt_r <= 3'd0;
          state_r      <= SETTLE;
        end
        SETTLE: begin
          // Give the PC time to update before the next address is sampled.
          if (settle_cnt_r == SETTLE_LAST) begin
            settle_cnt_r <= 3'd0;
            if (resume_s) state_r <= FETCH;
            else          state_r <= IDLE;
          end else begin
            settle_cnt_r <= settle_cnt_r + 3'd1;
          end
        end
        HALT: begin
          if (!bus.run) begin
            halted_r <= 1'b0;
            state_r  <= IDLE;
          end else begin
            state_r  <= HALT;
          end
        end
        default: begin
          state_r       <= IDLE;
          pc_enable_r   <= 1'b0;
          jmp_r         <= 1'b0;
          instr_valid_r <= 1'b0;
          halted_r      <= 1'b0;
          settle_cnt_r  <= 3'd0;
        end
      endcase
    end
  end

  assign bus.ir          = ir_r;
  assign bus.opcode      = op_s;
  assign bus.operand     = operand_s;
  assign bus.pc_enable   = pc_enable_r;
  assign bus.jmp         = jmp_r;
  assign bus.jmploc      = jmploc_r;
  assign bus.instr_valid = instr_valid_r;
  assign bus.halted      = halted_r;

endmodule
